// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block:
// FSM state encoding, terminal count default and debounce counter width.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVF   = 3'd4
  } state_t;

  localparam logic [15:0] COUNT_MAX_DEF = 16'hFFFF;
  localparam int unsigned DB_CNT_W      = 8;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Datapath-side bundle between the stopwatch controller and the counter / BCD chain.
// key_level exposes the debounced key levels for debug visibility.
interface stopwatch_ctrl_if;
  logic        tick;
  logic [15:0] count;
  logic        cnt_en;
  logic        cnt_clr;
  logic [15:0] disp_value;
  logic        lap_active;
  logic        overflow;
  logic [2:0]  state;
  logic [2:0]  key_level;

  modport master (
    input  tick, count,
    output cnt_en, cnt_clr, disp_value, lap_active, overflow, state, key_level
  );

  modport slave (
    output tick, count,
    input  cnt_en, cnt_clr, disp_value, lap_active, overflow, state, key_level
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchroniser, tick-based stability filter and
// a one-cycle press pulse on the accepted released->pressed transition.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic tick,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] LAST_TICK = DB_CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [DB_CNT_W-1:0] CNT_ZERO  = {DB_CNT_W{1'b0}};
  localparam logic [DB_CNT_W-1:0] CNT_ONE   = {{(DB_CNT_W-1){1'b0}}, 1'b1};

  logic                sync1_r;
  logic                sync2_r;
  logic                level_r;
  logic                press_r;
  logic [DB_CNT_W-1:0] stable_cnt_r;

  // Synchroniser for the asynchronous key input
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Any return to the accepted level restarts the stability count
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      level_r      <= 1'b1;
      press_r      <= 1'b0;
      stable_cnt_r <= CNT_ZERO;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        stable_cnt_r <= CNT_ZERO;
      end else if (tick) begin
        if (stable_cnt_r == LAST_TICK) begin
          level_r      <= sync2_r;
          stable_cnt_r <= CNT_ZERO;
          press_r      <= ~sync2_r;
        end else begin
          stable_cnt_r <= stable_cnt_r + CNT_ONE;
        end
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced key presses into counter enable,
// counter clear and a live or lap-frozen display value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter logic [15:0] COUNT_MAX      = COUNT_MAX_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              key_start_n,
  input  logic              key_lap_n,
  input  logic              key_clear_n,
  stopwatch_ctrl_if.master  dp
);

  logic   start_press_s, lap_press_s, clear_press_s;
  logic   start_level_s, lap_level_s, clear_level_s;
  logic   start_ev_s, lap_ev_s, clr_ev_s;
  logic   at_max_s, clr_req_s;
  state_t state_r, state_next_s;
  logic   cnt_clr_r, lap_r, ovf_r;
  logic [15:0] disp_r;

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_start (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tick(dp.tick),
    .key_n(key_start_n), .level(start_level_s), .press(start_press_s)
  );

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_lap (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tick(dp.tick),
    .key_n(key_lap_n), .level(lap_level_s), .press(lap_press_s)
  );

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_clear (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tick(dp.tick),
    .key_n(key_clear_n), .level(clear_level_s), .press(clear_press_s)
  );

  // Priority resolution happens before the state decides whether the winner matters
  assign clr_ev_s   = clear_press_s;
  assign start_ev_s = start_press_s & ~clear_press_s;
  assign lap_ev_s   = lap_press_s & ~start_press_s & ~clear_press_s;
  assign at_max_s   = (dp.count == COUNT_MAX);

  // Next-state and clear-request decode
  always_comb begin
    state_next_s = state_r;
    clr_req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_ev_s) begin
          clr_req_s = 1'b1;
        end else if (start_ev_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (at_max_s) begin
          state_next_s = ST_OVF;
        end else if (start_ev_s) begin
          state_next_s = ST_PAUSE;
        end else if (lap_ev_s) begin
          state_next_s = ST_LAP;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (at_max_s) begin
          state_next_s = ST_OVF;
        end else if (start_ev_s) begin
          state_next_s = ST_PAUSE;
        end else if (lap_ev_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (clr_ev_s) begin
          clr_req_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (start_ev_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      ST_OVF: begin
        if (clr_ev_s) begin
          clr_req_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OVF;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and registered datapath outputs; the lap snapshot is simply a held load
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_IDLE;
      cnt_clr_r <= 1'b0;
      disp_r    <= 16'd0;
      lap_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_clr_r <= clr_req_s;
      disp_r    <= (state_r == ST_LAP) ? disp_r : dp.count;
      lap_r     <= (state_next_s == ST_LAP);
      ovf_r     <= (state_next_s == ST_OVF);
    end
  end

  assign dp.cnt_en     = dp.tick & ((state_r == ST_RUN) | (state_r == ST_LAP)) & ~at_max_s;
  assign dp.cnt_clr    = cnt_clr_r;
  assign dp.disp_value = disp_r;
  assign dp.lap_active = lap_r;
  assign dp.overflow   = ovf_r;
  assign dp.state      = state_r;
  assign dp.key_level  = {start_level_s, lap_level_s, clear_level_s};

endmodule
